// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Control sequencer for the radix-2 FFT butterfly bank. It walks the datapath
// through LOAD, then NUM_STAGES passes of (RUN for MAC_CYCLES phases, one WB
// write-back cycle), then a one-cycle DONE pulse. Every output is a flop that
// loads the value belonging to the state being entered. Each output therefore
// changes on the same edge as the state it describes.

module fft_stage_sequencer #(
    parameter int NUM_STAGES = 5,   // log2 of FFT size, 1..7
    parameter int MAC_CYCLES = 4    // clk_MAC cycles per butterfly MAC, 2..8
) (
    input  logic                  clk_MAC,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  in_load,
    output logic [2:0]            count,
    output logic [2:0]            count_reg,
    output logic                  flag,
    output logic [2:0]            stage,
    output logic                  stage_we,
    output logic [NUM_STAGES-1:0] tw_stride,
    output logic                  busy,
    output logic                  done
);

    // State encoding is kept as plain constants so it can be probed and
    // matched against older netlists.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0]            LAST_COUNT = 3'(MAC_CYCLES - 1);
    localparam logic [2:0]            LAST_STAGE = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STRIDE_ONE = NUM_STAGES'(1);

    logic [2:0] state;
    logic [2:0] state_n;
    logic [2:0] count_n;
    logic [2:0] stage_n;

    // Next-state, next-phase and next-stage selection; abort overrides everything.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_n = state;
        count_n = 3'd0;
        stage_n = stage;

        case (state)
            S_IDLE: begin
                stage_n = 3'd0;
                if (start) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                stage_n = 3'd0;
                state_n = S_RUN;
            end
            S_RUN: begin
                if (count == LAST_COUNT) begin
                    state_n = S_WB;
                end else begin
                    count_n = count + 3'd1;
                end
            end
            S_WB: begin
                if (stage == LAST_STAGE) begin
                    state_n = S_DONE;
                end else begin
                    stage_n = stage + 3'd1;
                    state_n = S_RUN;
                end
            end
            S_DONE: begin
                stage_n = 3'd0;
                state_n = S_IDLE;
            end
            default: begin
                stage_n = 3'd0;
                state_n = S_IDLE;
            end
        endcase

        if (abort) begin
            state_n = S_IDLE;
            count_n = 3'd0;
            stage_n = 3'd0;
        end
    end

    // State register and registered outputs, decoded from the state being entered.
    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= 3'd0;
            count_reg <= 3'd0;
            stage     <= 3'd0;
            in_load   <= 1'b0;
            stage_we  <= 1'b0;
            flag      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tw_stride <= STRIDE_ONE << LAST_STAGE;
        end else begin
            // NOTE: non-blocking assignments here so count_reg picks up the old
            // count while count itself takes its new value on the same edge.
            state     <= state_n;
            count     <= count_n;
            count_reg <= count;
            stage     <= stage_n;
            in_load   <= (state_n == S_LOAD);
            stage_we  <= (state_n == S_WB);
            flag      <= (state_n == S_RUN) && (count_n == LAST_COUNT);
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            tw_stride <= STRIDE_ONE << (LAST_STAGE - stage_n);
        end
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
// Drives fft_stage_sequencer with directed and random start/abort patterns.
// A cycle-position reference model derives every output from "cycles since
// the transform started". Outputs are sampled on the falling edge.

module tb_fft_stage_sequencer;

    localparam int N   = 5;
    localparam int M   = 4;
    localparam int LAT = 2 + N * (M + 1);   // cycle index of the done pulse

    typedef struct packed {
        logic         in_load;
        logic [2:0]   count;
        logic [2:0]   count_reg;
        logic         flag;
        logic [2:0]   stage;
        logic         stage_we;
        logic [N-1:0] tw_stride;
        logic         busy;
        logic         done;
    } outs_t;

    logic         clk_MAC;
    logic         rst;
    logic         start;
    logic         abort;
    logic         in_load;
    logic [2:0]   count;
    logic [2:0]   count_reg;
    logic         flag;
    logic [2:0]   stage;
    logic         stage_we;
    logic [N-1:0] tw_stride;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: m_k is cycles since start (0 = idle), m_prev the prior count.
    int m_k    = 0;
    int m_prev = 0;

    fft_stage_sequencer #(
        .NUM_STAGES(N),
        .MAC_CYCLES(M)
    ) dut (
        .clk_MAC  (clk_MAC),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_load  (in_load),
        .count    (count),
        .count_reg(count_reg),
        .flag     (flag),
        .stage    (stage),
        .stage_we (stage_we),
        .tw_stride(tw_stride),
        .busy     (busy),
        .done     (done)
    );

    initial clk_MAC = 1'b0;
    always #5 clk_MAC = ~clk_MAC;

    // Expected outputs for position k of a transform: LOAD at k=1, stage s
    // spans k = 2+s*(M+1) .. 2+s*(M+1)+M, where the last slot is write-back.
    function automatic outs_t model_out(input int k, input int prev_cnt);
        outs_t e;
        int    j;
        int    s;
        int    p;
        e           = '0;
        e.count_reg = 3'(prev_cnt);
        e.tw_stride = N'(1 << (N - 1));
        if (k == 1) begin
            e.in_load = 1'b1;
            e.busy    = 1'b1;
        end else if (k >= 2 && k < LAT) begin
            j           = k - 2;
            s           = j / (M + 1);
            p           = j % (M + 1);
            e.busy      = 1'b1;
            e.stage     = 3'(s);
            e.tw_stride = N'(1 << (N - 1 - s));
            if (p < M) begin
                e.count = 3'(p);
                e.flag  = (p == M - 1);
            end else begin
                e.stage_we = 1'b1;
            end
        end else if (k == LAT) begin
            e.busy      = 1'b1;
            e.done      = 1'b1;
            e.stage     = 3'(N - 1);
            e.tw_stride = N'(1);
        end
        return e;
    endfunction

    function automatic outs_t dut_out();
        outs_t g;
        g = '{in_load, count, count_reg, flag, stage, stage_we, tw_stride, busy, done};
        return g;
    endfunction

    // Apply inputs for the current cycle, advance the model across the edge,
    // and land on the next falling edge ready to sample.
    task automatic tick(input logic s, input logic a);
        outs_t cur;
        start = s;
        abort = a;
        cur    = model_out(m_k, m_prev);
        m_prev = int'(cur.count);
        if (a)             m_k = 0;
        else if (m_k == 0) m_k = s ? 1 : 0;
        else if (m_k == LAT) m_k = 0;
        else               m_k = m_k + 1;
        @(posedge clk_MAC);
        @(negedge clk_MAC);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        outs_t g;
        outs_t e;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk_MAC);
        m_k    = 0;
        m_prev = 0;
        g = dut_out();
        e = model_out(m_k, m_prev);
        n_checks++;
        if (g !== e) $display("FAIL reset_held: got=%h expected=%h", g, e);
        else n_pass++;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(1'b0, 1'b0);
            g = dut_out();
            e = model_out(m_k, m_prev);
            n_checks++;
            if (g !== e) $display("FAIL reset_idle c%0d: got=%h expected=%h", c, g, e);
            else n_pass++;
        end
    endtask

    task automatic test_nominal();
        outs_t g;
        outs_t e;
        int    flag_at[$];
        int    we_at[$];
        int    done_at[$];
        int    exp_flag[5] = '{5, 10, 15, 20, 25};
        int    exp_we[5]   = '{6, 11, 16, 21, 26};
        for (int c = 0; c <= LAT + 2; c++) begin
            g = dut_out();
            e = model_out(m_k, m_prev);
            n_checks++;
            if (g !== e) $display("FAIL nominal c%0d: got=%h expected=%h", c, g, e);
            else n_pass++;
            if (flag)     flag_at.push_back(c);
            if (stage_we) we_at.push_back(c);
            if (done)     done_at.push_back(c);
            tick(c == 0, 1'b0);
        end
        n_checks++;
        if (flag_at.size() != 5 || we_at.size() != 5) begin
            $display("FAIL nominal_strobe_count: flag=%0d we=%0d required 5 each",
                     flag_at.size(), we_at.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (flag_at[i] != exp_flag[i] || we_at[i] != exp_we[i])
                    $display("FAIL nominal_strobe_pos %0d: flag@%0d we@%0d required %0d/%0d",
                             i, flag_at[i], we_at[i], exp_flag[i], exp_we[i]);
                else n_pass++;
            end
        end
        n_checks++;
        if (done_at.size() != 1 || done_at[0] != 27)
            $display("FAIL nominal_done: pulses=%0d first@%0d required 1 pulse @27",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        outs_t g;
        outs_t e;
        int    dones = 0;
        int    done_c = -1;
        for (int c = 0; c <= LAT + 4; c++) begin
            g = dut_out();
            e = model_out(m_k, m_prev);
            n_checks++;
            if (g !== e) $display("FAIL busy_start c%0d: got=%h expected=%h", c, g, e);
            else n_pass++;
            if (done) begin
                dones++;
                done_c = c;
            end
            tick(c == 0 || c == 10 || c == LAT, 1'b0);
        end
        n_checks++;
        if (dones != 1 || done_c != 27)
            $display("FAIL busy_start_done: pulses=%0d last@%0d required 1 @27", dones, done_c);
        else n_pass++;
    endtask

    task automatic test_abort();
        outs_t g;
        outs_t e;
        int    dones = 0;
        int    done_c = -1;
        for (int c = 0; c <= 50; c++) begin
            g = dut_out();
            e = model_out(m_k, m_prev);
            n_checks++;
            if (g !== e) $display("FAIL abort c%0d: got=%h expected=%h", c, g, e);
            else n_pass++;
            if (c == 14) begin
                n_checks++;
                if (busy !== 1'b0 || stage !== 3'd0)
                    $display("FAIL abort_idle: busy=%b stage=%0d required 0/0", busy, stage);
                else n_pass++;
            end
            if (done) begin
                dones++;
                done_c = c;
            end
            tick(c == 0 || c == 20, c == 13);
        end
        n_checks++;
        if (dones != 1 || done_c != 47)
            $display("FAIL abort_done: pulses=%0d last@%0d required 1 @47", dones, done_c);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        outs_t g;
        outs_t e;
        for (int c = 0; c <= 8; c++) begin
            tick(c == 0, 1'b0);
        end
        #2 rst = 1'b0;
        #1;
        m_k    = 0;
        m_prev = 0;
        g = dut_out();
        e = model_out(m_k, m_prev);
        n_checks++;
        if (g !== e) $display("FAIL async_reset: got=%h expected=%h", g, e);
        else n_pass++;
        @(negedge clk_MAC);
        rst = 1'b1;
        test_nominal();
    endtask

    task automatic test_random();
        outs_t g;
        outs_t e;
        logic  s;
        logic  a;
        for (int c = 0; c < 600; c++) begin
            g = dut_out();
            e = model_out(m_k, m_prev);
            n_checks++;
            if (g !== e) $display("FAIL random c%0d: got=%h expected=%h", c, g, e);
            else n_pass++;
            s = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 39) == 0);
            tick(s, a);
        end
        for (int c = 0; c < LAT + 2; c++) tick(1'b0, 1'b0);
        g = dut_out();
        e = model_out(m_k, m_prev);
        n_checks++;
        if (g !== e) $display("FAIL random_drain: got=%h expected=%h", g, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_start_while_busy();
        test_abort();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
